// File: rtl/data_memory_ctrl.sv
// ---------------------------------------------------------------------------
// data_memory_ctrl
//
// Single-port data memory for the core's load/store path.
//   - Synchronous read with one cycle of latency and a registered result.
//   - Byte-lane write strobes. Lanes with a strobe of 0 keep their old byte.
//   - Selectable read-during-write behaviour for a read and a write to the
//     same word in the same cycle.
//   - A built-in clear sequencer zero-fills the array after reset, or when
//     mem_clear is requested. Accesses are only accepted while 'ready' is high.
// The default parameters give the 8-bit x 256 map and timing of the original
// 8-bit data memory.
//
// Parameters
//   DATA_W    word width in bits (multiple of 8)
//   ADDR_W    address width, DEPTH = 2**ADDR_W words
//   RDW_MODE  same-address read during write: 0 = new data, 1 = old data
//
// Ports
//   clk          in   clock, rising edge
//   rst          in   asynchronous active-high reset
//   mem_read     in   read request, taken when ready = 1
//   mem_write    in   write request, taken when ready = 1
//   mem_clear    in   request a zero-fill of the whole array
//   addr         in   word address for read and write
//   wdata        in   write data
//   wstrb        in   byte-lane write enables, bit i covers wdata[8i+7:8i]
//   rdata        out  registered read data
//   rdata_valid  out  one-cycle pulse when rdata carries a new read result
//   ready        out  high when accesses are accepted, low while clearing
// ---------------------------------------------------------------------------
module data_memory_ctrl #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 8,
  parameter int RDW_MODE = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic                  mem_clear,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [DATA_W/8-1:0]   wstrb,
  output logic [DATA_W-1:0]     rdata,
  output logic                  rdata_valid,
  output logic                  ready
);

  localparam int LANES = DATA_W / 8;
  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {
    S_CLEAR = 1'b0,
    S_READY = 1'b1
  } state_t;

  state_t              state;
  logic [ADDR_W-1:0]   clr_cnt;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic [DATA_W-1:0]   cur_word;
  logic [DATA_W-1:0]   merged_word;
  logic                do_write;

  // The word at addr, and that word with the strobed lanes replaced by
  // wdata. The merged word is both what a write stores and what a
  // write-first read returns.
  always_comb begin
    cur_word    = mem[addr];
    merged_word = cur_word;
    for (int i = 0; i < LANES; i++) begin
      if (wstrb[i]) begin
        merged_word[8*i +: 8] = wdata[8*i +: 8];
      end
    end
  end

  // A clear request wins over a write that arrives in the same cycle.
  always_comb begin
    do_write = (state == S_READY) && !mem_clear && mem_write;
  end

  // The array itself has no reset. It is zeroed one word per cycle by the
  // clear sequence. Writes are held off while reset is asserted, so that
  // nothing lands in the array during reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == S_CLEAR) begin
        mem[clr_cnt] <= '0;
      end else if (do_write) begin
        mem[addr] <= merged_word;
      end
    end
  end

  // Control FSM with registered outputs.
  // CLEAR walks clr_cnt across the whole array. 'ready' rises together with
  // the move to READY, on the edge that writes the last word, so ready
  // comes up exactly DEPTH cycles after the clear starts.
  // In READY, a clear request restarts the sweep and drops any access that
  // arrives with it. rdata holds its value unless a read is accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_CLEAR;
      clr_cnt     <= '0;
      ready       <= 1'b0;
      rdata       <= '0;
      rdata_valid <= 1'b0;
    end else begin
      rdata_valid <= 1'b0;
      case (state)
        S_CLEAR: begin
          clr_cnt <= clr_cnt + ADDR_W'(1);
          if (clr_cnt == '1) begin
            state <= S_READY;
            ready <= 1'b1;
          end
        end
        S_READY: begin
          if (mem_clear) begin
            state   <= S_CLEAR;
            clr_cnt <= '0;
            ready   <= 1'b0;
          end else if (mem_read) begin
            rdata_valid <= 1'b1;
            if ((RDW_MODE == 0) && mem_write) begin
              rdata <= merged_word;
            end else begin
              rdata <= cur_word;
            end
          end
        end
        default: begin
          state <= S_CLEAR;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_memory_ctrl.sv
// ---------------------------------------------------------------------------
// tb_data_memory_ctrl
//
// Drives two instances of data_memory_ctrl in lock-step from the same
// stimulus:
//   dut_a  default build: 8-bit x 256, write-first
//   dut_b  32-bit x 256, read-first
// A reference model of each memory predicts every read result. Each
// prediction goes into a queue, tagged with the clock edge that must produce
// it. A monitor pops the queue and checks rdata_valid, rdata and ready
// after every rising edge.
// ---------------------------------------------------------------------------
module tb_data_memory_ctrl;

  logic        clk;
  logic        rst;
  logic        mem_read;
  logic        mem_write;
  logic        mem_clear;
  logic [7:0]  addr;
  logic [7:0]  wdata_a;
  logic [0:0]  wstrb_a;
  logic [31:0] wdata_b;
  logic [3:0]  wstrb_b;
  logic [7:0]  rdata_a;
  logic [31:0] rdata_b;
  logic        rdata_valid_a;
  logic        rdata_valid_b;
  logic        ready_a;
  logic        ready_b;

  typedef struct {
    logic [31:0] data;
    int          edge_no;
  } exp_t;

  exp_t        q_a[$];
  exp_t        q_b[$];
  exp_t        e_a;
  exp_t        e_b;
  logic        exp_v_a;
  logic        exp_v_b;

  logic [7:0]  m_mem_a [256];
  logic [31:0] m_mem_b [256];
  logic        m_ready;
  int          m_cnt;
  int          edge_cnt;
  int          vectors;
  int          miscompares;

  data_memory_ctrl #(.DATA_W(8), .ADDR_W(8), .RDW_MODE(0)) dut_a (
    .clk         (clk),
    .rst         (rst),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .mem_clear   (mem_clear),
    .addr        (addr),
    .wdata       (wdata_a),
    .wstrb       (wstrb_a),
    .rdata       (rdata_a),
    .rdata_valid (rdata_valid_a),
    .ready       (ready_a)
  );

  data_memory_ctrl #(.DATA_W(32), .ADDR_W(8), .RDW_MODE(1)) dut_b (
    .clk         (clk),
    .rst         (rst),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .mem_clear   (mem_clear),
    .addr        (addr),
    .wdata       (wdata_b),
    .wstrb       (wstrb_b),
    .rdata       (rdata_b),
    .rdata_valid (rdata_valid_b),
    .ready       (ready_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mergeWord(input logic [31:0] old_w, input logic [31:0] new_w,
                                            input logic [3:0] strb);
    logic [31:0] r;
    r = old_w;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) r[8*i +: 8] = new_w[8*i +: 8];
    end
    return r;
  endfunction

  task automatic modelReset();
    m_ready = 1'b0;
    m_cnt   = 0;
    q_a.delete();
    q_b.delete();
  endtask

  // Called at a falling edge. Drives one cycle of stimulus, advances the
  // model by the rising edge that follows, then waits for the next falling
  // edge.
  task automatic applyStimulus(input logic rd, input logic wr, input logic clr,
                               input logic [7:0] a, input logic [31:0] wd, input logic [3:0] ws);
    exp_t        ea;
    exp_t        eb;
    logic [7:0]  new_a;
    logic [31:0] new_b;
    mem_read  = rd;
    mem_write = wr;
    mem_clear = clr;
    addr      = a;
    wdata_a   = wd[7:0];
    wstrb_a   = ws[0:0];
    wdata_b   = wd;
    wstrb_b   = ws;
    if (m_ready) begin
      if (clr) begin
        m_ready = 1'b0;
        m_cnt   = 0;
        for (int i = 0; i < 256; i++) begin
          m_mem_a[i] = 8'h00;
          m_mem_b[i] = 32'h0;
        end
      end else begin
        new_a = 8'(mergeWord(32'(m_mem_a[a]), wd, {3'b000, ws[0]}));
        new_b = mergeWord(m_mem_b[a], wd, ws);
        if (rd) begin
          ea.data    = wr ? 32'(new_a) : 32'(m_mem_a[a]);
          ea.edge_no = edge_cnt + 1;
          eb.data    = m_mem_b[a];
          eb.edge_no = edge_cnt + 1;
          q_a.push_back(ea);
          q_b.push_back(eb);
        end
        if (wr) begin
          m_mem_a[a] = new_a;
          m_mem_b[a] = new_b;
        end
      end
    end else begin
      m_cnt++;
      if (m_cnt == 256) m_ready = 1'b1;
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 32'h0, 4'h0);
  endtask

  // Monitor: checks ready every cycle and matches rdata_valid/rdata against
  // the head of each scoreboard queue.
  always @(posedge clk) begin
    #1;
    edge_cnt++;
    checkOutput("ready_a", 32'(ready_a), 32'(m_ready));
    checkOutput("ready_b", 32'(ready_b), 32'(m_ready));
    exp_v_a = (q_a.size() != 0) && (q_a[0].edge_no <= edge_cnt);
    exp_v_b = (q_b.size() != 0) && (q_b[0].edge_no <= edge_cnt);
    checkOutput("valid_a", 32'(rdata_valid_a), 32'(exp_v_a));
    checkOutput("valid_b", 32'(rdata_valid_b), 32'(exp_v_b));
    if (exp_v_a) begin
      e_a = q_a.pop_front();
      if (rdata_valid_a) checkOutput("rdata_a", 32'(rdata_a), e_a.data);
    end
    if (exp_v_b) begin
      e_b = q_b.pop_front();
      if (rdata_valid_b) checkOutput("rdata_b", rdata_b, e_b.data);
    end
  end

  initial begin
    vectors     = 0;
    miscompares = 0;
    edge_cnt    = 0;
    rst         = 1'b1;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    mem_clear   = 1'b0;
    addr        = 8'h00;
    wdata_a     = 8'h00;
    wstrb_a     = 1'b0;
    wdata_b     = 32'h0;
    wstrb_b     = 4'h0;
    for (int i = 0; i < 256; i++) begin
      m_mem_a[i] = 8'h00;
      m_mem_b[i] = 32'h0;
    end
    modelReset();
    repeat (3) @(negedge clk);
    checkOutput("rst_rdata_a", 32'(rdata_a), 32'h0);
    checkOutput("rst_rdata_b", rdata_b, 32'h0);
    rst = 1'b0;

    // Write during the initial clear must be ignored.
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h0B, 32'h99999999, 4'hF);
    idle(255);

    // Freshly cleared words read as zero.
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 32'h0, 4'h0);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'hFF, 32'h0, 4'h0);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h0B, 32'h0, 4'h0);

    // Simple write/read, then a write with no strobes.
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h0A, 32'h000000AA, 4'h1);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h0A, 32'h0, 4'h0);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h0A, 32'h11111111, 4'h0);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h0A, 32'h0, 4'h0);

    // Partial-lane write.
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h30, 32'h12345678, 4'hF);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h30, 32'hAABBCCDD, 4'b0101);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h30, 32'h0, 4'h0);

    // Same-cycle read and write.
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h0A, 32'h00000033, 4'hF);
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h0A, 32'h000000FF, 4'h1);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h0A, 32'h0, 4'h0);

    // Clear with a simultaneous access: the access is dropped.
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h20, 32'h77777777, 4'hF);
    applyStimulus(1'b1, 1'b1, 1'b1, 8'h20, 32'h88888888, 4'hF);
    idle(256);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h20, 32'h0, 4'h0);

    // Reset in the middle of a clear sweep.
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h40, 32'h5C5C5C5C, 4'hF);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h40, 32'h0, 4'h0);
    idle(2);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h00, 32'h0, 4'h0);
    idle(100);
    #2;
    checkOutput("hold_rdata_a", 32'(rdata_a), 32'h5C);
    checkOutput("hold_rdata_b", rdata_b, 32'h5C5C5C5C);
    rst = 1'b1;
    #1;
    checkOutput("async_rdata_a", 32'(rdata_a), 32'h0);
    checkOutput("async_rdata_b", rdata_b, 32'h0);
    checkOutput("async_ready_a", 32'(ready_a), 32'h0);
    checkOutput("async_ready_b", 32'(ready_b), 32'h0);
    modelReset();
    @(negedge clk);
    rst = 1'b0;
    idle(256);

    // Stress: fill 0..63 and read it back.
    for (int i = 0; i < 64; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 8'(i), (32'h01010101 * 32'(8'(i) ^ 8'h5A)) ^ (32'(i) << 8), 4'hF);
    end
    for (int i = 0; i < 64; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 8'(i), 32'h0, 4'h0);
    end
    idle(3);
    checkOutput("drain_a", 32'(q_a.size()), 32'h0);
    checkOutput("drain_b", 32'(q_b.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
